// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer with per-set LRU and saturating direction counters.
// Optional hit/mispredict performance counters are enabled with `define BTB_PERF_EN.
module btb_2way #(
  parameter int SETS     = 8,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_stall,
  input  logic [31:0] pc_1,
  input  logic        len32_1,
  input  logic [31:0] pc_3,
  input  logic        len32_3,
  input  logic        is_branch_3,
  input  logic        taken_3,
  input  logic [31:0] target_3,
  input  logic        pred_taken_3,
  input  logic [31:0] pred_target_3,
  output logic        taken,
  output logic [31:0] branch_pc,
  output logic        flush
`ifdef BTB_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_mispred
`endif
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 31 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    logic [CTR_BITS-1:0] r;
    if (up) r = (c == CTR_MAX) ? c : c + CTR_ONE;
    else    r = (c == CTR_ZERO) ? c : c - CTR_ONE;
    return r;
  endfunction

  logic [1:0]          valid_q  [SETS];
  logic [1:0]          valid_d  [SETS];
  logic [TAG_W-1:0]    tag_q    [SETS][2];
  logic [TAG_W-1:0]    tag_d    [SETS][2];
  logic [31:0]         target_q [SETS][2];
  logic [31:0]         target_d [SETS][2];
  logic [CTR_BITS-1:0] ctr_q    [SETS][2];
  logic [CTR_BITS-1:0] ctr_d    [SETS][2];
  logic [SETS-1:0]     lru_q, lru_d;

  logic [IDX-1:0]   idx1_s, idx3_s;
  logic [TAG_W-1:0] tag1_s, tag3_s;
  logic [1:0]       hitv1_s, hitv3_s;
  logic             hit1_s, hit3_s, way1_s, way3_s, alloc_way_s, wr_way_s, wr_s;
  logic             mispred_s, taken_s;
  logic [31:0]      fall1_s, fall3_s;
  logic             unused_s;

  assign unused_s = &{1'b0, pc_1[0], pc_3[0]};

  // Tag lookup for the fetch PC and the resolving PC; way0 wins a double hit.
  always_comb begin
    idx1_s = pc_1[IDX:1];
    tag1_s = pc_1[31:IDX+1];
    idx3_s = pc_3[IDX:1];
    tag3_s = pc_3[31:IDX+1];
    for (int w = 0; w < 2; w++) begin
      hitv1_s[w] = valid_q[idx1_s][w] & (tag_q[idx1_s][w] == tag1_s);
      hitv3_s[w] = valid_q[idx3_s][w] & (tag_q[idx3_s][w] == tag3_s);
    end
    hit1_s  = |hitv1_s;
    hit3_s  = |hitv3_s;
    way1_s  = ~hitv1_s[0];
    way3_s  = ~hitv3_s[0];
    fall1_s = pc_1 + (len32_1 ? 32'd4 : 32'd2);
    fall3_s = pc_3 + (len32_3 ? 32'd4 : 32'd2);
  end

  // Prediction and mispredict redirect; a stage-3 redirect overrides the stage-1 prediction.
  always_comb begin
    taken_s   = hit1_s & ctr_q[idx1_s][way1_s][CTR_BITS-1];
    mispred_s = is_branch_3 & ((pred_taken_3 != taken_3) |
                               (pred_taken_3 & taken_3 & (pred_target_3 != target_3)));
    if (mispred_s)    branch_pc = taken_3 ? target_3 : fall3_s;
    else if (taken_s) branch_pc = target_q[idx1_s][way1_s];
    else              branch_pc = fall1_s;
    taken = taken_s;
    flush = mispred_s;
  end

  // Table and LRU next state; the stage-3 LRU write is last so it wins a shared set.
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    lru_d       = lru_q;
    alloc_way_s = ~valid_q[idx3_s][0] ? 1'b0 : (~valid_q[idx3_s][1] ? 1'b1 : lru_q[idx3_s]);
    wr_way_s    = hit3_s ? way3_s : alloc_way_s;
    wr_s        = ~memory_stall & is_branch_3 & (hit3_s | taken_3);
    lru_d[idx1_s] = (~memory_stall & hit1_s) ? ~way1_s : lru_q[idx1_s];
    if (wr_s) begin
      valid_d[idx3_s][wr_way_s] = 1'b1;
      tag_d[idx3_s][wr_way_s]   = tag3_s;
      if (!hit3_s || (taken_3 && (target_q[idx3_s][wr_way_s] != target_3))) begin
        target_d[idx3_s][wr_way_s] = target_3;
        ctr_d[idx3_s][wr_way_s]    = CTR_WEAK;
      end else begin
        ctr_d[idx3_s][wr_way_s] = ctr_step(ctr_q[idx3_s][wr_way_s], taken_3);
      end
      lru_d[idx3_s] = ~wr_way_s;
    end else begin
      valid_d[idx3_s] = valid_q[idx3_s];
    end
  end

  // Table state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        for (int w = 0; w < 2; w++) begin
          tag_q[s][w]    <= {TAG_W{1'b0}};
          target_q[s][w] <= 32'd0;
          ctr_q[s][w]    <= CTR_ZERO;
        end
      end
      lru_q <= {SETS{1'b0}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      lru_q    <= lru_d;
    end
  end

`ifdef BTB_PERF_EN
  logic [31:0] perf_hits_q, perf_hits_d, perf_mispred_q, perf_mispred_d;

  // Event counters advance only on non-stalled cycles.
  always_comb begin
    if (!memory_stall) begin
      perf_hits_d    = perf_hits_q + {31'd0, hit1_s};
      perf_mispred_d = perf_mispred_q + {31'd0, mispred_s};
    end else begin
      perf_hits_d    = perf_hits_q;
      perf_mispred_d = perf_mispred_q;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_hits_q    <= 32'd0;
      perf_mispred_q <= 32'd0;
    end else begin
      perf_hits_q    <= perf_hits_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_hits    = perf_hits_q;
  assign perf_mispred = perf_mispred_q;
`endif

endmodule

// File: tb/tb_btb_2way.sv
// Table-driven bench for btb_2way: per-cycle vectors with expected prediction/redirect outputs.
module tb_btb_2way;
  logic        clk = 1'b0;
  logic        rst_n, memory_stall, len32_1, len32_3, is_branch_3, taken_3, pred_taken_3;
  logic        taken, flush;
  logic [31:0] pc_1, pc_3, target_3, pred_target_3, branch_pc;
`ifdef BTB_PERF_EN
  logic [31:0] perf_hits, perf_mispred;
`endif

  always #5 clk = ~clk;

  btb_2way #(.SETS(8), .CTR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall),
    .pc_1(pc_1), .len32_1(len32_1), .pc_3(pc_3), .len32_3(len32_3),
    .is_branch_3(is_branch_3), .taken_3(taken_3), .target_3(target_3),
    .pred_taken_3(pred_taken_3), .pred_target_3(pred_target_3),
    .taken(taken), .branch_pc(branch_pc), .flush(flush)
`ifdef BTB_PERF_EN
    , .perf_hits(perf_hits), .perf_mispred(perf_mispred)
`endif
  );

  typedef struct packed {
    logic        s;
    logic [31:0] p1;
    logic        l1;
    logic        b3;
    logic [31:0] p3;
    logic        l3;
    logic        t3;
    logic [31:0] tg3;
    logic        pt3;
    logic [31:0] ptg3;
    logic        et;
    logic [31:0] ebp;
    logic        ef;
    logic        ct;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stage-1 lookup only: check taken and fall-through/target, no flush.
  function automatic vec_t lk(input logic [31:0] p1, input logic l1, input logic et, input logic [31:0] ebp);
    vec_t v;
    v = '0;
    v.p1 = p1; v.l1 = l1; v.et = et; v.ebp = ebp; v.ef = 1'b0; v.ct = 1'b1;
    return v;
  endfunction

  // Stage-3 branch resolution; taken not checked because flush may redirect.
  function automatic vec_t br(input logic s, input logic [31:0] p1, input logic l1,
                              input logic [31:0] p3, input logic l3, input logic t3,
                              input logic [31:0] tg3, input logic pt3, input logic [31:0] ptg3,
                              input logic ef, input logic [31:0] ebp);
    vec_t v;
    v = '0;
    v.s = s; v.p1 = p1; v.l1 = l1; v.b3 = 1'b1; v.p3 = p3; v.l3 = l3; v.t3 = t3;
    v.tg3 = tg3; v.pt3 = pt3; v.ptg3 = ptg3; v.ef = ef; v.ebp = ebp; v.ct = 1'b0;
    return v;
  endfunction

  task automatic drive_idle();
    memory_stall = 1'b0; pc_1 = 32'd0; len32_1 = 1'b0; pc_3 = 32'd0; len32_3 = 1'b0;
    is_branch_3 = 1'b0; taken_3 = 1'b0; target_3 = 32'd0; pred_taken_3 = 1'b0; pred_target_3 = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic apply(input int id, input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    memory_stall = v.s; pc_1 = v.p1; len32_1 = v.l1; is_branch_3 = v.b3; pc_3 = v.p3;
    len32_3 = v.l3; taken_3 = v.t3; target_3 = v.tg3; pred_taken_3 = v.pt3; pred_target_3 = v.ptg3;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (flush !== e.ef) begin
      n_bad++;
      $display("FAIL flush[%0d] got=%0b exp=%0b", id, flush, e.ef);
    end
    n_cmp++;
    if (branch_pc !== e.ebp) begin
      n_bad++;
      $display("FAIL branch_pc[%0d] got=%h exp=%h", id, branch_pc, e.ebp);
    end
    if (e.ct) begin
      n_cmp++;
      if (taken !== e.et) begin
        n_bad++;
        $display("FAIL taken[%0d] got=%0b exp=%0b", id, taken, e.et);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive_idle();

    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    tbl.push_back(lk(32'h100, 1'b0, 1'b0, 32'h102));
    tbl.push_back(br(1'b0, 32'h000, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200));
    tbl.push_back(br(1'b0, 32'h300, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104));
    tbl.push_back(br(1'b0, 32'h100, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h102));
    tbl.push_back(br(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104));
    tbl.push_back(br(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    tbl.push_back(br(1'b0, 32'h004, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200));
    tbl.push_back(br(1'b0, 32'h008, 1'b0, 32'h120, 1'b1, 1'b1, 32'h220, 1'b0, 32'h0, 1'b1, 32'h220));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200));
    tbl.push_back(br(1'b0, 32'h00C, 1'b1, 32'h140, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0, 1'b1, 32'h240));
    tbl.push_back(lk(32'h120, 1'b1, 1'b0, 32'h124));
    tbl.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200));
    tbl.push_back(lk(32'h140, 1'b1, 1'b1, 32'h240));
    tbl.push_back(br(1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 1'b1, 32'h240, 1'b1, 32'h240, 1'b0, 32'h200));
    tbl.push_back(br(1'b0, 32'h012, 1'b1, 32'h160, 1'b1, 1'b1, 32'h260, 1'b0, 32'h0, 1'b1, 32'h260));
    tbl.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    tbl.push_back(lk(32'h160, 1'b1, 1'b1, 32'h260));
    tbl.push_back(br(1'b1, 32'h020, 1'b1, 32'h052, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400));
    tbl.push_back(lk(32'h052, 1'b0, 1'b0, 32'h054));
    tbl.push_back(br(1'b0, 32'h020, 1'b1, 32'h052, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400));
    tbl.push_back(lk(32'h052, 1'b0, 1'b1, 32'h400));
    tbl.push_back(br(1'b0, 32'h020, 1'b1, 32'h052, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 32'h300));
    tbl.push_back(lk(32'h052, 1'b1, 1'b1, 32'h300));
    tbl.push_back(br(1'b0, 32'h020, 1'b1, 32'h052, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h056));
    tbl.push_back(lk(32'h052, 1'b1, 1'b0, 32'h056));
    tbl.push_back(lk(32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0));
    tbl.push_back(lk(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0));
    v = br(1'b0, 32'h200, 1'b1, 32'h070, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h204);
    v.b3 = 1'b0;
    tbl.push_back(v);
    tbl.push_back(lk(32'h070, 1'b1, 1'b0, 32'h074));
    tbl.push_back(br(1'b0, 32'h020, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0));
    tbl.push_back(lk(32'hFFFF_FFFE, 1'b1, 1'b0, 32'h2));
    tbl.push_back(br(1'b0, 32'h020, 1'b1, 32'h052, 1'b1, 1'b0, 32'h999, 1'b0, 32'h123, 1'b0, 32'h024));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Reset mid-run must empty the table.
    do_reset();
    apply(100, lk(32'h160, 1'b0, 1'b0, 32'h162));
    apply(101, lk(32'h052, 1'b1, 1'b0, 32'h056));

    // A stalled stage-1 hit must not touch LRU: 0x100 stays the eviction victim.
    apply(102, br(1'b0, 32'h002, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200));
    apply(103, br(1'b0, 32'h002, 1'b1, 32'h120, 1'b1, 1'b1, 32'h220, 1'b0, 32'h0, 1'b1, 32'h220));
    v = lk(32'h100, 1'b1, 1'b1, 32'h200);
    v.s = 1'b1;
    apply(104, v);
    apply(105, br(1'b0, 32'h002, 1'b1, 32'h140, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0, 1'b1, 32'h240));
    apply(106, lk(32'h100, 1'b1, 1'b0, 32'h104));
    apply(107, lk(32'h120, 1'b1, 1'b1, 32'h220));
    apply(108, lk(32'h140, 1'b1, 1'b1, 32'h240));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_2way.md
Name: btb_2way

Overview:
- Parametrised successor to the direct-mapped 8-entry BTB in the fetch stage.
- Organisation: 2-way set-associative, SETS configurable, per-set LRU, configurable saturating-counter width.
- RVC aware: halfword-granular indexing; fall-through selected by instruction length.
- Predicts at IF (stage 1) from pc_1; resolves and updates at EX (stage 3); raises flush with redirect PC on mispredict.

Parameters:
SETS, 8, number of sets; power of 2, >=2; IDX=log2(SETS)
CTR_BITS, 2, saturating direction-counter width, >=2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
memory_stall  in  1  freeze all state updates
pc_1  in  32  fetch PC (stage 1)
len32_1  in  1  1: 32-bit instr at pc_1; 0: 16-bit RVC
pc_3  in  32  PC of instr in stage 3
len32_3  in  1  length of instr at pc_3
is_branch_3  in  1  stage-3 instr is branch/jump
taken_3  in  1  resolved direction
target_3  in  32  resolved taken target
pred_taken_3  in  1  prediction made for this instr at stage 1
pred_target_3  in  32  target predicted for this instr at stage 1
taken  out  1  predicted taken for pc_1
branch_pc  out  32  next fetch PC (prediction or redirect)
flush  out  1  stage-3 mispredict; flush stages 1-2

Behaviour:
- Entry: valid, tag=pc[31:IDX+1], target[31:0], ctr[CTR_BITS-1:0]. Index=pc[IDX:1]. One LRU bit per set; value = way to evict.
- Reset (rst_n=0 at posedge): all valid=0, ctr=0, LRU=0. Outputs are combinational: with empty table, taken=0, flush=0, branch_pc=pc_1+(len32_1?4:2).
- Lookup (combinational, from registered state, no write bypass): hit_w = valid_w & tag match. Both ways hit: way0 wins.
- Lookup result: taken = hit & ctr[MSB]; branch_pc = taken ? target : pc_1+(len32_1?4:2).
- Mispredict = is_branch_3 & ((pred_taken_3!=taken_3) | (pred_taken_3 & taken_3 & pred_target_3!=target_3)).
- On mispredict: flush=1; branch_pc = taken_3 ? target_3 : pc_3+(len32_3?4:2). Overrides stage-1 prediction. flush is asserted even during memory_stall.
- Update occurs on the posedge only when !memory_stall & is_branch_3:
  - Hit, target unchanged or not taken: ctr saturating +1 if taken_3, -1 otherwise. Never wraps.
  - Hit, taken_3 and stored target != target_3: target<=target_3; ctr<=weak-taken (MSB=1, others 0).
  - Miss, taken_3: allocate. Choose invalid way0, else invalid way1, else LRU way. Write valid=1, tag, target_3, ctr=weak-taken.
  - Miss, not taken: no allocation.
- LRU (only when !memory_stall):
  - Stage-1 hit marks the hit way MRU (LRU=other way).
  - Stage-3 update/allocate marks the written way MRU.
  - Both touch the same set: stage 3 wins.
- memory_stall=1: no table or LRU change. Outputs remain combinational.
- Addition wraps modulo 2^32 (pc 0xFFFFFFFE+2=0).

Optional Feature:
Macro BTB_PERF_EN.
- Defined: adds outputs perf_hits[31:0] (stage-1 hits on non-stall cycles) and perf_mispred[31:0] (flush cycles with !memory_stall).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. After reset, pc_1=0x100, len32_1=1 -> taken=0, branch_pc=0x104, flush=0; len32_1=0 -> branch_pc=0x102.
2. Stage 3: pc_3=0x100, is_branch_3=1, taken_3=1, target_3=0x200, pred_taken_3=0 -> flush=1, branch_pc=0x200. Next cycle pc_1=0x100 -> taken=1, branch_pc=0x200.
3. Same branch resolved not-taken twice (pred_taken_3 matching counter state) -> ctr 10->01->00. pc_1=0x100 -> taken=0. A third not-taken keeps ctr=00.
4. SETS=8: allocate taken branches at 0x100, 0x120, 0x140 (same set). Hit 0x100 from stage 1 in between -> 0x120 evicted; 0x100 and 0x140 still hit.
5. memory_stall=1 with allocating branch -> flush=1 but no entry written (pc_1 lookup misses next cycle). Repeat with stall=0 -> entry written.
6. Hit entry, taken, pred_target_3=0x200, target_3=0x300 -> flush, branch_pc=0x300. Entry target becomes 0x300, ctr=10.
